// File: rtl/seg_display_scan_pkg.sv
// Shared constants and types for the seven-segment scan block.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_display_scan_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Index 0 is the rightmost entry of the concatenation.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_display_scan_hex.sv
// Combinational hex nibble to active-low segment pattern.
// Pure lookup, no state.
module hex_to_seg
    import seg_display_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the glyph for this nibble
    always_comb begin
        seg = SEG_LUT[nibble];
    end

endmodule

// File: rtl/seg_display_scan.sv
// Four-digit common-anode seven-segment scanner with
// per-digit blank, decimal point and blink control.
module seg_display_scan
    import seg_display_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp,
    input  logic [3:0]  blink,
    output logic [3:0]  segEn,
    output logic [6:0]  sevSeg,
    output logic        segDec,
    output logic        frame_tick
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_TC = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLK_TC = BW'(BLINK_DIV - 1);

    logic [15:0]   valueQ;
    logic [3:0]    blankQ;
    logic [3:0]    dpQ;
    logic [3:0]    blinkQ;
    logic [RW-1:0] refreshCnt;
    logic [BW-1:0] blinkCnt;
    logic          blinkPhase;
    digit_idx_t    digitIdx;

    logic          slotEnd;
    logic          blinkEnd;
    logic [3:0]    curNibble;
    logic [6:0]    curSeg;
    logic          curLit;

    assign slotEnd  = (refreshCnt == REF_TC);
    assign blinkEnd = (blinkCnt == BLK_TC);

    // Capture the display data on a load strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valueQ <= '0;
            blankQ <= 4'hF;
            dpQ    <= '0;
            blinkQ <= '0;
        end else if (load) begin
            valueQ <= value;
            blankQ <= blank;
            dpQ    <= dp;
            blinkQ <= blink;
        end
    end

    // Slot timer and digit selector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refreshCnt <= '0;
            digitIdx   <= '0;
        end else if (slotEnd) begin
            refreshCnt <= '0;
            digitIdx   <= digitIdx + 2'd1;
        end else begin
            refreshCnt <= refreshCnt + 1'b1;
        end
    end

    // Blink timer and visible/dark phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else if (blinkEnd) begin
            blinkCnt   <= '0;
            blinkPhase <= ~blinkPhase;
        end else begin
            blinkCnt <= blinkCnt + 1'b1;
        end
    end

    // Select the current digit's nibble and decide visibility
    always_comb begin
        curNibble = valueQ[{digitIdx, 2'b00} +: 4];
        curLit    = ~blankQ[digitIdx]
                  & ~(blinkQ[digitIdx] & blinkPhase);
    end

    hex_to_seg uHex (
        .nibble (curNibble),
        .seg    (curSeg)
    );

    // Register all pin outputs together so they never skew
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segEn      <= AN_OFF;
            sevSeg     <= SEG_OFF;
            segDec     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= slotEnd & (digitIdx == 2'd3);
            if (curLit) begin
                segEn  <= ~(4'b0001 << digitIdx);
                sevSeg <= curSeg;
                segDec <= ~dpQ[digitIdx];
            end else begin
                segEn  <= AN_OFF;
                sevSeg <= SEG_OFF;
                segDec <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan.
// Reference model works from elapsed-cycle arithmetic.
module tb_seg_display_scan;

    localparam int R = 4;
    localparam int B = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink = '0;
    logic [3:0]  segEn;
    logic [6:0]  sevSeg;
    logic        segDec;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] en;
        logic [6:0] seg;
        logic       dec;
        logic       ft;
    } out_t;

    localparam out_t RST_OUT = '{en: 4'hF, seg: 7'h7F, dec: 1'b1, ft: 1'b0};

    logic [6:0] lut [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    out_t        q[$];
    int          n = 0;
    logic [15:0] mValue = '0;
    logic [3:0]  mBlank = 4'hF;
    logic [3:0]  mDp = '0;
    logic [3:0]  mBlink = '0;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    seg_display_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank      (blank),
        .dp         (dp),
        .blink      (blink),
        .segEn      (segEn),
        .sevSeg     (sevSeg),
        .segDec     (segDec),
        .frame_tick (frame_tick)
    );

    // Output expected one edge after k elapsed edges since reset release
    function automatic out_t expectAt(int k);
        out_t e;
        int   idx;
        int   ph;
        bit   lit;
        idx = (k / R) % 4;
        ph  = (k / B) % 2;
        lit = !mBlank[idx] && !(mBlink[idx] && ph == 1);
        e   = RST_OUT;
        e.ft = ((k % (4 * R)) == 4 * R - 1);
        if (lit) begin
            e.en  = 4'hF & ~(4'(1) << idx);
            e.seg = lut[(mValue >> (4 * idx)) & 16'hF];
            e.dec = !mDp[idx];
        end
        return e;
    endfunction

    task automatic check(string name, out_t act, out_t exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s t=%0t: got en=%h seg=%h dec=%b ft=%b, expected en=%h seg=%h dec=%b ft=%b",
                     name, $time, act.en, act.seg, act.dec, act.ft,
                     exp.en, exp.seg, exp.dec, exp.ft);
        end
    endtask

    function automatic out_t dutOut();
        out_t o;
        o.en  = segEn;
        o.seg = sevSeg;
        o.dec = segDec;
        o.ft  = frame_tick;
        return o;
    endfunction

    // Model: predict the next output and track captured data
    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0;
            mValue = '0;
            mBlank = 4'hF;
            mDp = '0;
            mBlink = '0;
        end else begin
            q.push_back(expectAt(n));
            if (load) begin
                mValue = value;
                mBlank = blank;
                mDp = dp;
                mBlink = blink;
            end
            n++;
        end
    end

    // Monitor: compare every cycle's outputs against the queue
    always @(negedge clk) begin
        out_t e;
        if (!rst_n || q.size() == 0) e = RST_OUT;
        else e = q.pop_front();
        check("scan", dutOut(), e);
    end

    task automatic doLoad(logic [15:0] v, logic [3:0] b, logic [3:0] d, logic [3:0] k);
        @(negedge clk);
        value = v;
        blank = b;
        dp = d;
        blink = k;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        value = 16'($urandom);
        blank = 4'($urandom);
        dp = 4'($urandom);
        blink = 4'($urandom);
    endtask

    task automatic cycles(int c);
        repeat (c) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(64);

        doLoad(16'h12AF, 4'b0000, 4'b0100, 4'b0000);
        cycles(40);
        doLoad(16'h8888, 4'b1010, 4'b0000, 4'b0000);
        cycles(40);
        doLoad(16'h0005, 4'b0000, 4'b0000, 4'b0001);
        cycles(300);

        begin
            int guard = 0;
            while (!(((n / R) % 4) == 2 && (n % R) == 1) && guard < 64) begin
                @(posedge clk);
                guard++;
            end
            if (guard >= 64) check("wait_digit2", RST_OUT, '0);
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            q.delete();
            #1;
            check("async_reset", dutOut(), RST_OUT);
            cycles(3);
            rst_n = 1'b1;
        end
        cycles(32);

        for (int v = 0; v < 16; v++) begin
            doLoad(16'(v), 4'b1110, 4'(v & 1), 4'b0000);
            cycles(16);
        end

        for (int i = 0; i < 120; i++) begin
            logic [3:0] b;
            b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            doLoad(16'($urandom), b, 4'($urandom), 4'($urandom));
            cycles($urandom_range(0, 20));
        end

        cycles(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
